// File: rtl/serial_frame_rx_if.sv
// Bundles the serial bit input and the deframed word outputs of serial_frame_rx.
// Latency: none, wires only.
// Backpressure: none; the bit source never stalls and the consumer must take data while valid=1.
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              in;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              par_err;
    logic              busy;
    logic [7:0]        frame_cnt;

    // Bit source / frame consumer side.
    modport master (
        output in,
        input  data,
        input  valid,
        input  par_err,
        input  busy,
        input  frame_cnt
    );

    // Receiver side.
    modport slave (
        input  in,
        output data,
        output valid,
        output par_err,
        output busy,
        output frame_cnt
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Hunts a serial bitstream for a sync pattern, then deframes DATA_W payload bits plus even parity.
// Latency: last sync bit at edge N -> valid (or par_err) high in the cycle after edge N+DATA_W+1.
// Backpressure: none; one bit is consumed every clk and the word is presented for one cycle only.
module serial_frame_rx #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_frame_rx_if.slave   bus
);

    localparam int BW = $clog2(DATA_W);
    localparam int FW = $clog2(SYNC_W + 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(SYNC_W);
    localparam logic [FW-1:0] FILL_MIN  = FW'(SYNC_W - 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;

    // Only SYNC_W-1 history bits are kept; the incoming bit completes the candidate.
    logic [SYNC_W-2:0]   sync_sr_q;
    logic [FW-1:0]       fill_q;
    logic [BW-1:0]       bitcnt_q;
    logic                acc_q;
    logic [DATA_W-1:0]   shreg_q;

    logic [DATA_W-1:0]   data_q;
    logic                valid_q;
    logic                par_err_q;
    logic                busy_q;
    logic [7:0]          frame_cnt_q;

    logic [SYNC_W-1:0]   sync_shift;
    logic                sync_match;
    logic                par_ok;

    assign sync_shift = {sync_sr_q, bus.in};
    assign sync_match = (fill_q >= FILL_MIN) && (sync_shift == SYNC_PAT);
    assign par_ok     = ((acc_q ^ bus.in) == 1'b0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: hunt for sync, count payload bits, then take one parity bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (sync_match) state_d = DATA;
            DATA:    if (bitcnt_q == LAST_BIT) state_d = PARITY;
            PARITY:  state_d = HUNT;
            default: state_d = HUNT;
        endcase
    end

    // Datapath: sync history, payload shifter, parity accumulator and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_sr_q   <= '0;
            fill_q      <= '0;
            bitcnt_q    <= '0;
            acc_q       <= 1'b0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            busy_q    <= (state_d != HUNT);
            case (state_q)
                HUNT: begin
                    sync_sr_q <= sync_shift[SYNC_W-2:0];
                    if (fill_q != FILL_FULL) begin
                        fill_q <= fill_q + 1'b1;
                    end
                    if (sync_match) begin
                        bitcnt_q <= '0;
                        acc_q    <= 1'b0;
                    end
                end
                DATA: begin
                    shreg_q  <= {shreg_q[DATA_W-2:0], bus.in};
                    acc_q    <= acc_q ^ bus.in;
                    bitcnt_q <= bitcnt_q + 1'b1;
                end
                PARITY: begin
                    if (par_ok) begin
                        data_q      <= shreg_q;
                        valid_q     <= 1'b1;
                        frame_cnt_q <= frame_cnt_q + 8'd1;
                    end else begin
                        par_err_q <= 1'b1;
                    end
                    // A new sync must be seen entirely after this frame.
                    sync_sr_q <= '0;
                    fill_q    <= '0;
                end
                default: begin
                    sync_sr_q <= '0;
                    fill_q    <= '0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.par_err   = par_err_q;
    assign bus.busy      = busy_q;
    assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: directed frames plus a random bitstream against a queue-based model.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: none; one bit driven per cycle on the falling edge.
module tb_serial_frame_rx;

    localparam int              DATA_W   = 8;
    localparam int              SYNC_W   = 4;
    localparam logic [SYNC_W-1:0] SYNC_PAT = 4'b1011;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    serial_frame_rx_if #(.DATA_W(DATA_W)) sif ();

    serial_frame_rx #(
        .DATA_W   (DATA_W),
        .SYNC_W   (SYNC_W),
        .SYNC_PAT (SYNC_PAT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int edge_cnt = 0;
    int last_vld_edge = -1;
    int first_sync_edge = 0;
    int vld_seen = 0;
    int perr_seen = 0;

    // Reference model: bits since the last frame end, bits of the frame being collected.
    bit                hunt_q[$];
    bit                frame_q[$];
    bit                m_in_frame;
    logic [DATA_W-1:0] e_data;
    logic              e_valid;
    logic              e_perr;
    logic [7:0]        e_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hunt_q.delete();
        frame_q.delete();
        m_in_frame = 1'b0;
        e_data  = '0;
        e_valid = 1'b0;
        e_perr  = 1'b0;
        e_cnt   = '0;
    endtask

    task automatic model_step(input bit b);
        int v;
        int ones;
        logic [DATA_W-1:0] word;
        e_valid = 1'b0;
        e_perr  = 1'b0;
        if (!m_in_frame) begin
            hunt_q.push_back(b);
            if (hunt_q.size() > SYNC_W) void'(hunt_q.pop_front());
            if (hunt_q.size() == SYNC_W) begin
                v = 0;
                for (int i = 0; i < SYNC_W; i++) v = v * 2 + int'(hunt_q[i]);
                if (v == int'(SYNC_PAT)) begin
                    m_in_frame = 1'b1;
                    frame_q.delete();
                end
            end
        end else begin
            frame_q.push_back(b);
            if (frame_q.size() == DATA_W + 1) begin
                ones = 0;
                word = '0;
                for (int i = 0; i < DATA_W; i++) begin
                    word = {word[DATA_W-2:0], frame_q[i]};
                    ones += int'(frame_q[i]);
                end
                ones += int'(b);
                if (ones % 2 == 0) begin
                    e_valid = 1'b1;
                    e_data  = word;
                    e_cnt   = e_cnt + 8'd1;
                end else begin
                    e_perr = 1'b1;
                end
                m_in_frame = 1'b0;
                hunt_q.delete();
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".data"},  32'(sif.data),      32'(e_data));
        check({tag, ".valid"}, 32'(sif.valid),     32'(e_valid));
        check({tag, ".perr"},  32'(sif.par_err),   32'(e_perr));
        check({tag, ".busy"},  32'(sif.busy),      32'(m_in_frame));
        check({tag, ".cnt"},   32'(sif.frame_cnt), 32'(e_cnt));
    endtask

    task automatic send_bit(input bit b, input string tag);
        @(negedge clk);
        sif.in = b;
        model_step(b);
        @(posedge clk);
        edge_cnt++;
        #1;
        if (sif.valid === 1'b1) begin
            last_vld_edge = edge_cnt;
            vld_seen++;
        end
        if (sif.par_err === 1'b1) perr_seen++;
        check_all(tag);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] word, input bit par, input string tag);
        logic [SYNC_W-1:0] s;
        s = SYNC_PAT;
        first_sync_edge = edge_cnt + 1;
        for (int i = SYNC_W - 1; i >= 0; i--) send_bit(s[i], tag);
        for (int i = DATA_W - 1; i >= 0; i--) send_bit(word[i], tag);
        send_bit(par, tag);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < cycles; i++) begin
            #1;
            check_all("reset");
            @(negedge clk);
            sif.in = ~sif.in;
        end
        sif.in = 1'b0;
        rst_n  = 1'b1;
    endtask

    initial begin
        logic [DATA_W-1:0] w;
        logic [SYNC_W-1:0] s;
        int base;
        sif.in = 1'b0;
        model_reset();

        // 1. Reset with toggling input, then an idle stream of zeros.
        do_reset(2);
        for (int i = 0; i < 20; i++) send_bit(1'b0, "idle");

        // 2. Good frame A5 with latency measured from the first sync bit.
        last_vld_edge = -1;
        send_frame(8'hA5, 1'b0, "good");
        check("lat", 32'(last_vld_edge - first_sync_edge), 32'd12);
        check("goodA5.data", 32'(sif.data), 32'hA5);
        check("goodA5.cnt", 32'(sif.frame_cnt), 32'd1);

        // 3. Bad parity: data and count hold.
        perr_seen = 0;
        send_frame(8'hA5, 1'b1, "badpar");
        check("badpar.seen", 32'(perr_seen), 32'd1);
        check("badpar.data", 32'(sif.data), 32'hA5);
        check("badpar.cnt", 32'(sif.frame_cnt), 32'd1);
        send_bit(1'b0, "badpar.after");

        // 4. Overlapping sync lead-in, then back-to-back frame.
        send_bit(1'b1, "ovl");
        send_bit(1'b0, "ovl");
        send_frame(8'hF0, 1'b0, "b2b1");
        check("b2b1.data", 32'(sif.data), 32'hF0);
        send_frame(8'h01, 1'b1, "b2b2");
        check("b2b2.data", 32'(sif.data), 32'h01);
        check("b2b2.cnt", 32'(sif.frame_cnt), 32'd3);

        // 5. Reset during payload bit 4 aborts the frame.
        s = SYNC_PAT;
        for (int i = SYNC_W - 1; i >= 0; i--) send_bit(s[i], "abort");
        w = 8'h3C;
        for (int i = DATA_W - 1; i >= DATA_W - 4; i--) send_bit(w[i], "abort");
        vld_seen = 0;
        perr_seen = 0;
        do_reset(1);
        for (int i = 0; i < 6; i++) send_bit(1'b0, "abort.idle");
        check("abort.novld", 32'(vld_seen + perr_seen), 32'd0);
        send_frame(8'h5A, 1'b0, "postrst");
        check("postrst.data", 32'(sif.data), 32'h5A);
        check("postrst.cnt", 32'(sif.frame_cnt), 32'd1);

        // 6. Counter wrap over 256 good frames.
        do_reset(1);
        vld_seen = 0;
        for (int f = 0; f < 256; f++) send_frame(8'h00, 1'b0, "wrap");
        check("wrap.pulses", 32'(vld_seen), 32'd256);
        check("wrap.cnt", 32'(sif.frame_cnt), 32'd0);

        // Random stream: frames with random payload/parity interleaved with noise.
        for (int it = 0; it < 150; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                w = DATA_W'($urandom);
                send_frame(w, 1'($urandom_range(0, 1)), "rand.frame");
            end else begin
                base = $urandom_range(1, 6);
                for (int i = 0; i < base; i++) send_bit(1'($urandom_range(0, 1)), "rand.noise");
            end
            check("rand.excl", 32'(sif.valid & sif.par_err), 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
